// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants and the per-layer configuration record for
//               the VGA layer compositor.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int C_RGB_W      = 24;
  localparam int C_CW_DEFAULT = 11;
  // Stored window fields are this wide; coordinate widths up to this value
  // are supported and narrower coordinates are zero-extended into it.
  localparam int C_CW_MAX     = 16;

  localparam logic [C_RGB_W-1:0] C_BACK_DEFAULT = 24'h000000;

  typedef struct packed {
    logic                enable;
    logic                blink;
    logic [C_CW_MAX-1:0] pos_x;
    logic [C_CW_MAX-1:0] pos_y;
    logic [C_CW_MAX-1:0] size_x;
    logic [C_CW_MAX-1:0] size_y;
  } layer_cfg_t;

  localparam layer_cfg_t C_LAYER_OFF = '0;

endpackage
`default_nettype wire

// File: rtl/vga_layer_window.sv
`default_nettype none
// ============================================================================
// Module      : vga_layer_window
// Description : One overlay layer: shadow and active configuration entries,
//               the frame-boundary commit copy and the registered
//               visibility (window hit, enable, blink) for the pixel issued.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_layer_window
  import vga_pkg::*;
#(
  parameter int P_CW = C_CW_DEFAULT
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_cfg_we,
  input  logic            i_enable,
  input  logic            i_blink,
  input  logic [P_CW-1:0] i_pos_x,
  input  logic [P_CW-1:0] i_pos_y,
  input  logic [P_CW-1:0] i_size_x,
  input  logic [P_CW-1:0] i_size_y,
  input  logic            i_copy,
  input  logic [P_CW-1:0] i_x,
  input  logic [P_CW-1:0] i_y,
  input  logic            i_blink_phase,
  output logic            o_vis
);

  // One extra bit so pos+size can never wrap around.
  localparam int C_EW = C_CW_MAX + 1;

  layer_cfg_t       r_shadow;
  layer_cfg_t       r_active;
  layer_cfg_t       w_cfg;
  logic [C_EW-1:0]  w_x;
  logic [C_EW-1:0]  w_y;
  logic [C_EW-1:0]  w_x_lo;
  logic [C_EW-1:0]  w_x_hi;
  logic [C_EW-1:0]  w_y_lo;
  logic [C_EW-1:0]  w_y_hi;
  logic             w_hit;
  logic             w_vis;

  assign w_cfg = '{enable: i_enable,
                   blink:  i_blink,
                   pos_x:  C_CW_MAX'(i_pos_x),
                   pos_y:  C_CW_MAX'(i_pos_y),
                   size_x: C_CW_MAX'(i_size_x),
                   size_y: C_CW_MAX'(i_size_y)};

  assign w_x    = C_EW'(i_x);
  assign w_y    = C_EW'(i_y);
  assign w_x_lo = {1'b0, r_active.pos_x};
  assign w_y_lo = {1'b0, r_active.pos_y};
  assign w_x_hi = {1'b0, r_active.pos_x} + {1'b0, r_active.size_x};
  assign w_y_hi = {1'b0, r_active.pos_y} + {1'b0, r_active.size_y};

  // A zero size makes lo == hi, so the half-open range is empty.
  assign w_hit = (w_x >= w_x_lo) & (w_x < w_x_hi) &
                 (w_y >= w_y_lo) & (w_y < w_y_hi);
  assign w_vis = r_active.enable & w_hit & ~(r_active.blink & i_blink_phase);

  // Shadow entry takes accepted configuration writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_shadow <= C_LAYER_OFF;
    else if (i_cfg_we) r_shadow <= w_cfg;
  end

  // Active entry only changes at a frame boundary, all layers together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_active <= C_LAYER_OFF;
    else if (i_copy) r_active <= r_shadow;
  end

  // Visibility of the pixel issued this cycle, presented one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_vis <= 1'b0;
    else o_vis <= w_vis;
  end

endmodule
`default_nettype wire

// File: rtl/vga_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module      : vga_layer_compositor
// Description : Scans the display, issues pixel coordinates, and composites
//               up to 16 overlay layers over a background with per-layer
//               windows, blink and frame-synchronous config commits.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int  P_DISPLAY_X    = 1024,
  parameter int  P_DISPLAY_Y    = 768,
  parameter int  P_LAYERS       = 8,
  parameter int  P_CW           = C_CW_DEFAULT,
  parameter int  P_BLINK_FRAMES = 32,
  localparam int C_LW           = (P_LAYERS > 1) ? $clog2(P_LAYERS) : 1
)(
  input  logic                        VGA_CLK,
  input  logic                        RST_N,
  input  logic                        VGA_IF_RGBEN,
  output logic [P_CW-1:0]             CURRENT_X,
  output logic [P_CW-1:0]             CURRENT_Y,
  output logic                        FRAME_START,
  input  logic [P_LAYERS*C_RGB_W-1:0] LAYER_RGB,
  input  logic [P_LAYERS-1:0]         LAYER_OPAQUE,
  input  logic [C_RGB_W-1:0]          BACK_RGB,
  input  logic                        CFG_VALID,
  output logic                        CFG_READY,
  input  logic [C_LW-1:0]             CFG_LAYER,
  input  logic                        CFG_ENABLE,
  input  logic                        CFG_BLINK,
  input  logic [P_CW-1:0]             CFG_POS_X,
  input  logic [P_CW-1:0]             CFG_POS_Y,
  input  logic [P_CW-1:0]             CFG_SIZE_X,
  input  logic [P_CW-1:0]             CFG_SIZE_Y,
  input  logic                        CFG_COMMIT,
  output logic                        COMMIT_PENDING,
  output logic [C_RGB_W-1:0]          VGA_BUF_RGB,
  output logic                        RGB_VALID
);

  localparam logic [P_CW-1:0] C_X_LAST = P_CW'(P_DISPLAY_X - 1);
  localparam logic [P_CW-1:0] C_Y_LAST = P_CW'(P_DISPLAY_Y - 1);
  localparam int              C_BW     = $clog2(P_BLINK_FRAMES + 1);
  localparam logic [C_BW-1:0] C_B_LAST = C_BW'(P_BLINK_FRAMES - 1);

  logic [P_CW-1:0]    r_x;
  logic [P_CW-1:0]    r_y;
  logic               r_pending;
  logic [C_BW-1:0]    r_bcnt;
  logic               r_bphase;
  logic               r_v1;
  logic [P_LAYERS-1:0] w_vis;
  logic               w_x_last;
  logic               w_y_last;
  logic               w_frame_end;
  logic               w_idle_origin;
  logic               w_copy;
  logic               w_cfg_fire;
  logic [C_RGB_W-1:0] w_sel;

  assign w_x_last      = (r_x == C_X_LAST);
  assign w_y_last      = (r_y == C_Y_LAST);
  assign w_frame_end   = VGA_IF_RGBEN & w_x_last & w_y_last;
  assign w_idle_origin = ~VGA_IF_RGBEN & (r_x == '0) & (r_y == '0);
  // Copy only between frames so no frame ever sees mixed configuration.
  assign w_copy        = r_pending & (w_frame_end | w_idle_origin);

  assign CURRENT_X      = r_x;
  assign CURRENT_Y      = r_y;
  assign FRAME_START    = ~RST_N & VGA_IF_RGBEN & (r_x == '0) & (r_y == '0);
  assign COMMIT_PENDING = r_pending;
  assign CFG_READY      = ~RST_N & ~r_pending;
  assign w_cfg_fire     = CFG_VALID & CFG_READY;

  // Raster scan counter, advancing only on issued pixels.
  always_ff @(posedge VGA_CLK or posedge RST_N) begin
    if (RST_N) begin
      r_x <= '0;
      r_y <= '0;
    end else if (VGA_IF_RGBEN) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + P_CW'(1);
      end else begin
        r_x <= r_x + P_CW'(1);
      end
    end
  end

  // Blink frame counter; phase toggles every P_BLINK_FRAMES frames.
  always_ff @(posedge VGA_CLK or posedge RST_N) begin
    if (RST_N) begin
      r_bcnt   <= '0;
      r_bphase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_bcnt == C_B_LAST) begin
        r_bcnt   <= '0;
        r_bphase <= ~r_bphase;
      end else begin
        r_bcnt <= r_bcnt + C_BW'(1);
      end
    end
  end

  // Commit request: cleared by the copy, repeated requests ignored.
  always_ff @(posedge VGA_CLK or posedge RST_N) begin
    if (RST_N) r_pending <= 1'b0;
    else if (w_copy) r_pending <= 1'b0;
    else if (CFG_COMMIT) r_pending <= 1'b1;
  end

  // Priority select: the lowest-index visible opaque layer wins.
  always_comb begin
    w_sel = BACK_RGB;
    for (int i = P_LAYERS - 1; i >= 0; i--) begin
      if (w_vis[i] & LAYER_OPAQUE[i]) w_sel = LAYER_RGB[i*C_RGB_W +: C_RGB_W];
    end
  end

  // Output pipeline: issue -> stage 1 (select) -> registered pixel.
  always_ff @(posedge VGA_CLK or posedge RST_N) begin
    if (RST_N) begin
      r_v1        <= 1'b0;
      RGB_VALID   <= 1'b0;
      VGA_BUF_RGB <= C_BACK_DEFAULT;
    end else begin
      r_v1      <= VGA_IF_RGBEN;
      RGB_VALID <= r_v1;
      if (r_v1) VGA_BUF_RGB <= w_sel;
    end
  end

  generate
    for (genvar g = 0; g < P_LAYERS; g++) begin : g_layer
      vga_layer_window #(
        .P_CW (P_CW)
      ) u_window (
        .clk           (VGA_CLK),
        .rst           (RST_N),
        .i_cfg_we      (w_cfg_fire & (CFG_LAYER == C_LW'(g))),
        .i_enable      (CFG_ENABLE),
        .i_blink       (CFG_BLINK),
        .i_pos_x       (CFG_POS_X),
        .i_pos_y       (CFG_POS_Y),
        .i_size_x      (CFG_SIZE_X),
        .i_size_y      (CFG_SIZE_Y),
        .i_copy        (w_copy),
        .i_x           (r_x),
        .i_y           (r_y),
        .i_blink_phase (r_bphase),
        .o_vis         (w_vis[g])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_layer_compositor
// Description : Directed self-checking bench for vga_layer_compositor on an
//               8x4 display with 5 layers and a 2-frame blink half-period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_layer_compositor;

  localparam int DX = 8;
  localparam int DY = 4;
  localparam int NL = 5;
  localparam int CW = 11;
  localparam int BF = 2;

  typedef struct {
    bit en;
    bit bl;
    int px;
    int py;
    int sx;
    int sy;
  } mcfg_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            rgben;
  logic [CW-1:0]   cur_x, cur_y;
  logic            fs;
  logic [NL*24-1:0] layer_rgb;
  logic [NL-1:0]   layer_opq;
  logic [23:0]     back;
  logic            cfg_valid, cfg_ready;
  logic [2:0]      cfg_layer;
  logic            cfg_en, cfg_bl;
  logic [CW-1:0]   cfg_px, cfg_py, cfg_sx, cfg_sy;
  logic            cfg_commit, pending;
  logic [23:0]     out_rgb;
  logic            out_valid;

  // Bench-side model
  mcfg_t        sh[NL];
  mcfg_t        ac[NL];
  logic [23:0]  lrgb[NL];
  logic [NL-1:0] lopq;
  int           mx, my, bcnt;
  bit           bph, mpend, mv1;
  logic [23:0]  last_out;
  logic [23:0]  exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  vga_layer_compositor #(
    .P_DISPLAY_X    (DX),
    .P_DISPLAY_Y    (DY),
    .P_LAYERS       (NL),
    .P_CW           (CW),
    .P_BLINK_FRAMES (BF)
  ) dut (
    .VGA_CLK        (clk),
    .RST_N          (rst),
    .VGA_IF_RGBEN   (rgben),
    .CURRENT_X      (cur_x),
    .CURRENT_Y      (cur_y),
    .FRAME_START    (fs),
    .LAYER_RGB      (layer_rgb),
    .LAYER_OPAQUE   (layer_opq),
    .BACK_RGB       (back),
    .CFG_VALID      (cfg_valid),
    .CFG_READY      (cfg_ready),
    .CFG_LAYER      (cfg_layer),
    .CFG_ENABLE     (cfg_en),
    .CFG_BLINK      (cfg_bl),
    .CFG_POS_X      (cfg_px),
    .CFG_POS_Y      (cfg_py),
    .CFG_SIZE_X     (cfg_sx),
    .CFG_SIZE_Y     (cfg_sy),
    .CFG_COMMIT     (cfg_commit),
    .COMMIT_PENDING (pending),
    .VGA_BUF_RGB    (out_rgb),
    .RGB_VALID      (out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_layers();
    for (int i = 0; i < NL; i++) layer_rgb[i*24 +: 24] = lrgb[i];
    layer_opq = lopq;
  endtask

  task automatic cfg_set(input int l, input bit en, input bit bl,
                         input int px, input int py, input int sx, input int sy);
    cfg_layer = 3'(l);
    cfg_en    = en;
    cfg_bl    = bl;
    cfg_px    = CW'(px);
    cfg_py    = CW'(py);
    cfg_sx    = CW'(sx);
    cfg_sy    = CW'(sy);
  endtask

  function automatic bit vis(input int i);
    return ac[i].en && !(ac[i].bl && bph) &&
           mx >= ac[i].px && mx < ac[i].px + ac[i].sx &&
           my >= ac[i].py && my < ac[i].py + ac[i].sy;
  endfunction

  task automatic model_clear();
    mx = 0; my = 0; bcnt = 0; bph = 0; mpend = 0; mv1 = 0;
    last_out = 24'h0;
    exp_q.delete();
    for (int i = 0; i < NL; i++) begin
      sh[i] = '{default: 0};
      ac[i] = '{default: 0};
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check pipe.
  task automatic cycle(input bit en, input bit wr, input bit cm);
    logic [23:0] sel;
    logic [23:0] e;
    bit exp_fs, exp_valid, fire, last, bound;
    int l;
    rgben      = en;
    cfg_valid  = wr;
    cfg_commit = cm;
    exp_fs = en && mx == 0 && my == 0;
    if (en) begin
      sel = back;
      for (int i = NL - 1; i >= 0; i--) if (vis(i) && lopq[i]) sel = lrgb[i];
      exp_q.push_back(sel);
    end
    @(negedge clk);
    chk("cur_x", 32'(cur_x), 32'(mx));
    chk("cur_y", 32'(cur_y), 32'(my));
    chk("frame_start", 32'(fs), 32'(exp_fs));
    chk("cfg_ready", 32'(cfg_ready), 32'(!mpend));
    chk("commit_pending", 32'(pending), 32'(mpend));
    fire  = wr && !mpend;
    last  = en && mx == DX - 1 && my == DY - 1;
    bound = last || (!en && mx == 0 && my == 0);
    l = int'(cfg_layer);
    if (fire && l < NL)
      sh[l] = '{en: cfg_en, bl: cfg_bl, px: int'(cfg_px), py: int'(cfg_py),
                sx: int'(cfg_sx), sy: int'(cfg_sy)};
    if (mpend && bound) begin
      ac = sh;
      mpend = 0;
    end else if (cm && !mpend) begin
      mpend = 1;
    end
    if (last) begin
      if (bcnt == BF - 1) begin
        bcnt = 0;
        bph  = !bph;
      end else begin
        bcnt++;
      end
    end
    if (en) begin
      if (mx == DX - 1) begin
        mx = 0;
        my = (my == DY - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    exp_valid = mv1;
    mv1 = en;
    @(posedge clk);
    #1;
    chk("rgb_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      e = exp_q.pop_front();
      chk("pixel", 32'(out_rgb), 32'(e));
      last_out = e;
    end else begin
      chk("pixel_held", 32'(out_rgb), 32'(last_out));
    end
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    rgben = 1'b1;
    model_clear();
    @(negedge clk);
    chk("rst_cur_x", 32'(cur_x), 0);
    chk("rst_cur_y", 32'(cur_y), 0);
    chk("rst_frame_start", 32'(fs), 0);
    chk("rst_rgb", 32'(out_rgb), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 0);
    chk("rst_pending", 32'(pending), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rgben = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0;
    cfg_set(0, 0, 0, 0, 0, 0, 0);
    lrgb[0] = 24'h111111; lrgb[1] = 24'h00FF00; lrgb[2] = 24'hFF0000;
    lrgb[3] = 24'h333333; lrgb[4] = 24'h444444;
    lopq = '1;
    back = 24'h000000;
    apply_layers();
    do_reset();

    // Free-running scan with no layers: wraps and FRAME_START every 32 cycles
    repeat (64) cycle(1, 0, 0);

    // Layer 2 window at (2,1) size (3,2)
    cfg_set(2, 1, 0, 2, 1, 3, 2);
    cycle(0, 1, 1);
    repeat (2) cycle(0, 0, 0);
    repeat (32) cycle(1, 0, 0);
    repeat (2) cycle(0, 0, 0);

    // Layers 0 and 3 overlapping at (5,0): priority then opacity
    cfg_set(0, 1, 0, 5, 0, 1, 1);
    cycle(0, 1, 0);
    cfg_set(3, 1, 0, 4, 0, 3, 1);
    cycle(0, 1, 1);
    cycle(0, 0, 0);
    repeat (32) cycle(1, 0, 0);
    repeat (2) cycle(0, 0, 0);
    lopq[0] = 1'b0;
    back = 24'h0000AA;
    apply_layers();
    repeat (32) cycle(1, 0, 0);
    repeat (2) cycle(0, 0, 0);
    lopq[0] = 1'b1;
    apply_layers();

    // Write + commit mid-frame at (4,2); repeat commit and write while pending
    repeat (20) cycle(1, 0, 0);
    cfg_set(2, 1, 0, 0, 3, 8, 1);
    cycle(1, 1, 1);
    cfg_set(4, 1, 0, 0, 0, 8, 4);
    cycle(1, 1, 1);
    repeat (10) cycle(1, 0, 0);
    repeat (32) cycle(1, 0, 0);
    repeat (2) cycle(0, 0, 0);

    // Out-of-range layer indices are accepted and discarded
    cfg_set(6, 1, 0, 0, 0, 8, 4);
    cycle(0, 1, 0);
    cfg_set(7, 1, 0, 0, 0, 8, 4);
    cycle(0, 1, 1);
    cycle(0, 0, 0);
    repeat (32) cycle(1, 0, 0);
    repeat (2) cycle(0, 0, 0);

    // Blink layer from a fresh reset: shown, shown, hidden, hidden, shown
    do_reset();
    cfg_set(1, 1, 1, 0, 0, 8, 4);
    cycle(0, 1, 1);
    cycle(0, 0, 0);
    repeat (160) cycle(1, 0, 0);

    // Reset while a commit is pending at (6,3)
    repeat (30) cycle(1, 0, 0);
    cfg_set(0, 1, 0, 0, 0, 8, 4);
    cycle(1, 1, 1);
    do_reset();
    repeat (32) cycle(1, 0, 0);
    repeat (2) cycle(0, 0, 0);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_layer_compositor.md
VGA_LAYER_COMPOSITOR -- requirements
Module: vga_layer_compositor

Interface
REQ-001 SHALL have parameter P_DISPLAY_X, default 1024, meaning the active pixels per line.
REQ-002 SHALL have parameter P_DISPLAY_Y, default 768, meaning the active lines per frame.
REQ-003 SHALL have parameter P_LAYERS, default 8, meaning the overlay layer count (1..16).
REQ-004 SHALL have parameter P_CW, default 11, meaning the coordinate width.
REQ-005 SHALL have parameter P_BLINK_FRAMES, default 32, meaning the frames per blink half-period (>=1).
REQ-006 SHALL have port VGA_CLK  in  1  the single clock; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port RST_N  in  1  the asynchronous, active-high reset (the port name is kept for consistency; polarity is high).
REQ-008 SHALL have port VGA_IF_RGBEN  in  1  the pixel request; 1 = issue the current pixel this cycle.
REQ-009 SHALL have port CURRENT_X / CURRENT_Y  out  P_CW each  the coordinates of the pixel being issued.
REQ-010 SHALL have port FRAME_START  out  1  a pulse in the cycle pixel (0,0) is issued.
REQ-011 SHALL have port LAYER_RGB  in  P_LAYERS*24  the per-layer colour, valid 1 cycle after issue.
REQ-012 SHALL have port LAYER_OPAQUE  in  P_LAYERS  the per-layer pixel-opaque flag, valid 1 cycle after issue.
REQ-013 SHALL have port BACK_RGB  in  24  the background colour, valid 1 cycle after issue.
REQ-014 SHALL have port CFG_VALID / CFG_READY  in / out  1 / 1  the shadow-config write handshake.
REQ-015 SHALL have port CFG_LAYER  in  clog2(P_LAYERS)  the target layer index.
REQ-016 SHALL have port CFG_ENABLE, CFG_BLINK  in  1 each  the layer enable and the blink enable.
REQ-017 SHALL have port CFG_POS_X, CFG_POS_Y, CFG_SIZE_X, CFG_SIZE_Y  in  P_CW each  the layer window.
REQ-018 SHALL have port CFG_COMMIT  in  1  the request to apply the shadow config at the next frame boundary.
REQ-019 SHALL have port COMMIT_PENDING  out  1  high while a commit is waiting.
REQ-020 SHALL have port VGA_BUF_RGB / RGB_VALID  out  24 / 1  the composited pixel and its qualifier.

Function
REQ-021 SHALL run the scan counter as follows when VGA_IF_RGBEN=1: x increments; when x=P_DISPLAY_X-1, x wraps to 0 and y increments; when y=P_DISPLAY_Y-1 at line end, y wraps to 0; when RGBEN=0, the counter holds.
REQ-022 SHALL evaluate each layer's window hit in the issue cycle, using the active registers: POS<=coord<POS+SIZE, compared at P_CW+1 bits so that there is no overflow; SIZE=0 SHALL never hit; the result is registered.
REQ-023 SHALL treat a layer as visible when active_enable & hit & !(active_blink & blink_phase), with blink_phase sampled in the issue cycle.
REQ-024 SHALL, 1 cycle after issue, select the lowest-index layer that is visible and has LAYER_OPAQUE=1; if none qualifies, BACK_RGB SHALL be selected.
REQ-025 SHALL register the selection into VGA_BUF_RGB with RGB_VALID=1 exactly 2 cycles after the issue cycle; pixels with RGBEN=0 SHALL produce RGB_VALID=0 with VGA_BUF_RGB held.
REQ-026 SHALL, on a CFG_VALID&CFG_READY write, update the shadow entry for CFG_LAYER; an index >=P_LAYERS SHALL be accepted and discarded.
REQ-027 SHALL drive CFG_READY = !COMMIT_PENDING when out of reset.
REQ-028 SHALL, on CFG_COMMIT, set COMMIT_PENDING; if a CFG write and CFG_COMMIT occur in the same cycle, the write SHALL land first; CFG_COMMIT while pending SHALL be ignored.
REQ-029 SHALL copy all shadow entries to active when pending, at the edge ending the cycle that issues the last pixel of a frame, or at any edge where RGBEN=0 and the counter is (0,0); pending SHALL clear at that edge.
REQ-030 SHALL ensure that no frame is ever composed from mixed old and new active config.
REQ-031 SHALL advance the blink frame counter at each frame wrap; at P_BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_phase.

Reset
REQ-032 SHALL set the following on reset: counter (0,0), CURRENT_X/Y=0, FRAME_START=0, VGA_BUF_RGB=0, RGB_VALID=0, CFG_READY=0, COMMIT_PENDING=0, blink counter and phase 0, all shadow and active entries 0 (disabled).
REQ-033 SHALL, on reset mid-frame or mid-commit, abandon everything with no pending commit surviving; CFG_READY SHALL rise in the first cycle after release.

Structure
REQ-034 SHALL place in shared package vga_pkg: RGB width 24, the coordinate-width default, the layer-config record type (enable, blink, pos_x, pos_y, size_x, size_y) and the default background colour.
REQ-035 SHALL use sub-module vga_layer_window, instantiated P_LAYERS times, to hold the shadow/active entry, perform the commit copy and do the registered hit compare.

Verification
REQ-036 SHALL cover the following directed scenario: with P_DISPLAY_X=8, P_DISPLAY_Y=4 and RGBEN held high, CURRENT wraps 7->0 and y 3->0, and FRAME_START pulses every 32 cycles.
REQ-037 SHALL cover the following directed scenario: layer 2 at pos(2,1) size(3,2), opaque, RGB=FF0000 and BACK=000000 give pixels (2..4,1..2)=FF0000 and others=000000, each at 2-cycle latency.
REQ-038 SHALL cover the following directed scenario: layers 0 and 3 both covering (5,0), both opaque, output layer-0 RGB; with LAYER_OPAQUE[0]=0 the output is layer-3 RGB.
REQ-039 SHALL cover the following directed scenario: a write plus COMMIT at pixel (4,2) leaves the rest of that frame unchanged and applies the new config from the next (0,0); CFG_READY=0 until the wrap edge.
REQ-040 SHALL cover the following directed scenario: with P_BLINK_FRAMES=2 and a blink layer, the layer is shown for frames 0-1, hidden for frames 2-3 and shown again for frame 4.
REQ-041 SHALL cover the following directed scenario: reset asserted while pending at pixel (6,3) results in all outputs 0, COMMIT_PENDING=0 and layers disabled after release.
